timer_scheduler: RTL and testbench
==================================

// Module: timer_scheduler
// PURPOSE
//  Shares one 4-bit countdown timer (start / count / timer_reached handshake)
//  among NREQ requesters. Round-robin arbitration picks a requester, loads its
//  count into the timer, waits for timer_reached, then returns a one-cycle done
//  pulse to that requester. A watchdog aborts a job if the timer never reports.
//  Sits between the client logic and the single shared timer instance.
// PARAMETERS
//  NREQ    4    number of requesters (2..8)
//  CW      4    count width; must match the timer's ui_in_count
//  WDOG    64   max cycles in RUN before a forced timeout (>=2^CW+2)
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  rst            in   1        synchronous reset, active-high
//  req            in   NREQ     level request per requester
//  req_count      in   NREQ*CW  count for requester i at [i*CW +: CW]
//  grant          out  NREQ     one-hot owner of timer, LOAD..DONE
//  done           out  NREQ     one-hot 1-cycle completion pulse
//  timeout        out  1        1-cycle pulse with done when watchdog fired
//  busy           out  1        1 when state != IDLE
//  timer_start    out  1        1-cycle start pulse to shared timer
//  timer_count    out  CW       count presented to timer (held LOAD..RUN)
//  timer_reached  in   1        shared timer expiry indication
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, rr_ptr=0, all outputs 0. Aborts any
//    job in progress; no done/timeout is issued for it.
//  - FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE; all outputs registered.
//  - IDLE: if |req, select first i with req[i]=1 searching rr_ptr, rr_ptr+1, ...
//    (mod NREQ). Latch sel=i and cnt=req_count[i]. Next LOAD. No req: stay.
//  - LOAD (1 cycle): grant[sel]=1, timer_start=1, timer_count=cnt.
//    If cnt==0: skip timer, next DONE (timer_start stays 0). Else next RUN.
//  - RUN: grant[sel]=1, timer_count=cnt, wdog counts up from 0 per cycle.
//    timer_reached=1 -> DONE. wdog==WDOG-1 without reached -> DONE, timeout set.
//    timer_reached in IDLE/LOAD/DONE is ignored.
//  - DONE (1 cycle): done[sel]=1, timeout=1 if watchdog fired, grant held;
//    rr_ptr <= sel+1 mod NREQ. Next IDLE.
//  - Latency: req sampled in IDLE at cycle t -> timer_start at t+1;
//    timer_reached at cycle r -> done at r+1; back in IDLE at r+2.
//    cnt==0: done at t+2.
//  - req is level-sensitive; dropping req after selection does not cancel.
//    Requester must drop req by the DONE cycle or it is re-arbitrated.
//  - Only one job in flight; other reqs wait. Round-robin guarantees each
//    asserted req is served within NREQ jobs.
//  - req_count is sampled only in IDLE; later changes have no effect.
// TESTING
//  1 Single: req=0001, count0=5, timer model reaches 5 cycles after start ->
//    timer_start at t+1 with timer_count=5, done=0001 one cycle after reached.
//  2 Round-robin: req=1111 held, counts 1..4 -> grant order 0,1,2,3,0; each
//    done one-hot, exactly one per job.
//  3 Zero count: req=0100, count2=0 -> no timer_start, done=0100 at t+2.
//  4 Watchdog: req=0010, count=7, timer_reached tied 0 -> done=0010 and
//    timeout=1 together, WDOG cycles after entering RUN.
//  5 Reset mid-RUN: rst=1 during RUN -> next cycle grant=0, busy=0, no done;
//    then req=1000 served first (rr_ptr=0 search finds 3).
//  6 Spurious reached: timer_reached=1 while IDLE -> no state change, done=0.

Source files
------------

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one countdown timer among NREQ requesters,
// with a watchdog that aborts a job whose timer never reports expiry.
module timer_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int WDOG = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_count,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               timeout,
    output logic               busy,
    output logic               timer_start,
    output logic [CW-1:0]      timer_count,
    input  logic               timer_reached
);

    localparam int          SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          WW = $clog2(WDOG + 1);
    localparam int unsigned NU = NREQ;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   sel;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wdog;

    logic            pick_valid;
    logic [SW-1:0]   pick_idx;
    logic [CW-1:0]   pick_cnt;
    logic [SW-1:0]   rr_next;
    int unsigned     scan_idx;

    function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First asserted request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_cnt   = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NU;
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = SW'(scan_idx);
                pick_cnt   = req_count[scan_idx*CW +: CW];
            end
        end
    end

    assign rr_next = (sel == SW'(NREQ - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel         <= '0;
            cnt         <= '0;
            wdog        <= '0;
            grant       <= '0;
            done        <= '0;
            timeout     <= '0;
            busy        <= 1'b0;
            timer_start <= 1'b0;
            timer_count <= '0;
        end else begin
            done        <= '0;
            timeout     <= 1'b0;
            timer_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state       <= LOAD;
                        sel         <= pick_idx;
                        cnt         <= pick_cnt;
                        grant       <= onehot(pick_idx);
                        busy        <= 1'b1;
                        timer_start <= (pick_cnt != '0);
                        timer_count <= pick_cnt;
                    end
                end
                LOAD: begin
                    wdog <= '0;
                    if (cnt == '0) begin
                        state       <= DONE;
                        done        <= onehot(sel);
                        rr_ptr      <= rr_next;
                        timer_count <= '0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (timer_reached) begin
                        state       <= DONE;
                        done        <= onehot(sel);
                        rr_ptr      <= rr_next;
                        timer_count <= '0;
                    end else if (wdog == WW'(WDOG - 1)) begin
                        state       <= DONE;
                        done        <= onehot(sel);
                        timeout     <= 1'b1;
                        rr_ptr      <= rr_next;
                        timer_count <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: single job, round-robin, zero count,
// watchdog, reset mid-run and spurious timer_reached.
module tb_timer_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int WDOG = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] req_count;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               timeout;
    logic               busy;
    logic               timer_start;
    logic [CW-1:0]      timer_count;
    logic               timer_reached;

    int n_cmp = 0;
    int n_err = 0;

    timer_scheduler #(.NREQ(NREQ), .CW(CW), .WDOG(WDOG)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_count     (req_count),
        .grant         (grant),
        .done          (done),
        .timeout       (timeout),
        .busy          (busy),
        .timer_start   (timer_start),
        .timer_count   (timer_count),
        .timer_reached (timer_reached)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_sel [5];
        logic [3:0] jc;
        exp_sel = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

        rst = 1'b1; req = '0; req_count = '0; timer_reached = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_start", 32'(timer_start), 32'h0);
        chk("rst_tmo", 32'(timeout), 32'h0);

        // 1: single job, timer reaches 5 cycles after start
        req = 4'b0001; req_count = 16'h0005;
        tick();
        chk("t1_start", 32'(timer_start), 32'h1);
        chk("t1_count", 32'(timer_count), 32'h5);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        req = '0;
        tick();
        chk("t1_start_pulse", 32'(timer_start), 32'h0);
        chk("t1_count_held", 32'(timer_count), 32'h5);
        tick(); tick(); tick();
        chk("t1_nodone_run", 32'(done), 32'h0);
        tick();
        timer_reached = 1'b1;
        tick();
        timer_reached = 1'b0;
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_tmo", 32'(timeout), 32'h0);
        chk("t1_grant_done", 32'(grant), 32'h1);
        tick();
        chk("t1_done_clr", 32'(done), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_grant", 32'(grant), 32'h0);

        // 2: round-robin from rr_ptr=0, all requesters held
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; req_count = 16'h4321;
        for (int j = 0; j < 5; j++) begin
            jc = exp_sel[j] + 4'd1;
            tick();
            chk("t2_grant", 32'(grant), 32'(4'b0001 << exp_sel[j]));
            chk("t2_start", 32'(timer_start), 32'h1);
            chk("t2_count", 32'(timer_count), 32'(jc));
            for (int k = 1; k <= int'(jc); k++) begin
                tick();
                chk("t2_nodone", 32'(done), 32'h0);
                if (k == int'(jc)) timer_reached = 1'b1;
            end
            tick();
            timer_reached = 1'b0;
            chk("t2_done", 32'(done), 32'(4'b0001 << exp_sel[j]));
            chk("t2_tmo", 32'(timeout), 32'h0);
            if (j == 4) req = '0;
            tick();
            chk("t2_idle_done", 32'(done), 32'h0);
        end
        chk("t2_end_busy", 32'(busy), 32'h0);

        // 3: zero count skips the timer
        req = 4'b0100; req_count = 16'h0000;
        tick();
        chk("t3_nostart", 32'(timer_start), 32'h0);
        chk("t3_grant", 32'(grant), 32'h4);
        chk("t3_nodone", 32'(done), 32'h0);
        req = '0;
        tick();
        chk("t3_done", 32'(done), 32'h4);
        chk("t3_tmo", 32'(timeout), 32'h0);
        tick();
        chk("t3_idle", 32'(busy), 32'h0);

        // 4: watchdog fires WDOG cycles after entering RUN
        req = 4'b0010; req_count = 16'h0070;
        tick();
        chk("t4_start", 32'(timer_start), 32'h1);
        req = '0;
        tick();
        chk("t4_run_done0", 32'(done), 32'h0);
        for (int i = 1; i < WDOG; i++) begin
            tick();
            chk("t4_run_done", 32'(done), 32'h0);
        end
        tick();
        chk("t4_done", 32'(done), 32'h2);
        chk("t4_tmo", 32'(timeout), 32'h1);
        tick();
        chk("t4_tmo_clr", 32'(timeout), 32'h0);
        chk("t4_idle", 32'(busy), 32'h0);

        // 5: reset during RUN aborts silently, rr_ptr back to 0
        req = 4'b0001; req_count = 16'h0009;
        tick();
        req = '0;
        tick(); tick();
        chk("t5_run_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        req = 4'b1000; req_count = 16'h2000;
        tick();
        chk("t5_nodone_after", 32'(done), 32'h0);
        chk("t5_grant3", 32'(grant), 32'h8);
        chk("t5_count", 32'(timer_count), 32'h2);
        req = '0;
        tick(); tick();
        timer_reached = 1'b1;
        tick();
        timer_reached = 1'b0;
        chk("t5_done3", 32'(done), 32'h8);
        tick();

        // 6: timer_reached while IDLE is ignored
        timer_reached = 1'b1;
        tick();
        timer_reached = 1'b0;
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_grant", 32'(grant), 32'h0);
        tick();
        chk("t6_busy2", 32'(busy), 32'h0);
        chk("t6_start", 32'(timer_start), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
